dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Data-memory responder: the memory-side end of the processor's load/store interface.
- Accepts one load or store request per transaction over a valid/ready handshake.
- Applies RISC-V byte-lane placement and load sign/zero extension, inserts configurable wait states, and returns a response over a second valid/ready handshake.
- Serves as the data memory of the unpipelined core and as a bench responder for core testbenches.

Parameters:
- DEPTH_WORDS, 256: number of 32-bit words in the internal array. Valid byte addresses are 0 to DEPTH_WORDS*4-1.
- WAIT_CYCLES, 2: wait states between request acceptance and memory access. Legal range is 0 to 15.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-low (0 = reset, sampled on the rising edge of clk).
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_funct3  in  3  size code: 000 = B, 001 = H, 010 = W, 100 = BU, 101 = HU.
- req_wdata  in  32  store data as the raw rs2 value, right-aligned. Lane shifting is done internally.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  requester accepts the response.
- rsp_rdata  out  32  extended load result; 0 for stores and errors.
- rsp_err  out  1  request faulted.

Behaviour:
- Reset (rst=0 at an edge):
  - state = IDLE, wait counter = 0.
  - rsp_valid = 0, rsp_rdata = 0, rsp_err = 0.
  - req_ready = 1 in the cycle after reset.
  - Memory array is not cleared.
- Reset mid-operation: aborts any transaction. A store that has not yet committed is dropped.
- FSM states:
  - IDLE: req_ready = 1. On req_valid && req_ready, latch we/addr/funct3/wdata. Go to RESP_PREP when WAIT_CYCLES = 0, otherwise go to WAIT with counter = WAIT_CYCLES-1.
  - WAIT: req_ready = 0. Decrement the counter each cycle; at 0 go to RESP_PREP.
  - RESP_PREP: single cycle. Perform the access: store commits on this edge, load reads the array. Register rsp_rdata and rsp_err, then go to RESP.
  - RESP: rsp_valid = 1. rsp_rdata and rsp_err are held stable until rsp_valid && rsp_ready; on that edge go to IDLE and clear rsp_valid.
- Latency: rsp_valid rises exactly WAIT_CYCLES+2 edges after the accept edge.
- Throughput: minimum of WAIT_CYCLES+3 cycles per transaction; no overlap.
- req_ready is 0 in every state except IDLE. req_valid outside IDLE is ignored.
- Error conditions (no write, rsp_rdata = 0, rsp_err = 1):
  - H/HU with addr[0] != 0.
  - W with addr[1:0] != 0.
  - addr >= DEPTH_WORDS*4.
  - funct3 of 011, 110 or 111.
  - A store with funct3 100 or 101.
- Store lanes:
  - SB writes wdata[7:0] to byte addr[1:0].
  - SH writes wdata[15:0] to halfword addr[1].
  - SW writes the full word.
  - Other bytes of the word are unchanged.
- Load extension:
  - B/H sign-extend from bit 7/15 of the selected lane.
  - BU/HU zero-extend.
  - W returns the word unchanged.
- Word index is addr[log2(DEPTH_WORDS)+1:2].
- Read-after-write: a load following a store to the same word returns the updated data.

Decomposition:
- Shared package dmem_pkg holds:
  - funct3 size constants (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - FSM state encoding (IDLE, WAIT, RESP_PREP, RESP).
- One combinational sub-module, dmem_lane_align, is natural. It contains:
  - Store path: inputs are wdata, addr[1:0] and funct3; outputs are a 4-bit byte-enable and the shifted write word.
  - Load path: inputs are the raw word, addr[1:0] and funct3; output is the extended result.
  - Misalignment and illegal-funct3 detection, produced as a fault flag.

Test Plan:
- Reset: hold rst=0 for 2 cycles -> req_ready=1, rsp_valid=0, rsp_rdata=0x00000000, rsp_err=0.
- SW 0xDEADBEEF to 0x10, then LW from 0x10 with WAIT_CYCLES=2 -> rsp_valid rises 4 edges after each accept; load returns 0xDEADBEEF with rsp_err=0.
- SB 0x80 to 0x13 -> LB 0x13 returns 0xFFFFFF80; LBU 0x13 returns 0x00000080; LW 0x10 returns 0x80ADBEEF; LH 0x12 returns 0xFFFF80AD.
- SH to 0x11 -> rsp_err=1 and LW 0x10 still returns 0x80ADBEEF. LW 0x400 with DEPTH_WORDS=256 -> rsp_err=1, rsp_rdata=0. funct3=011 -> rsp_err=1.
- Backpressure: hold rsp_ready=0 for 5 cycles during RESP -> rsp_valid, rsp_rdata and rsp_err stay stable, req_ready=0, and a req_valid pulse is ignored (no second response appears).
- Drive rst=0 for one cycle while in WAIT during SW 0x12345678 to 0x20 -> FSM returns to IDLE; a later LW 0x20 returns the pre-store value.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: load/store size codes
// and the responder FSM state encoding.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP_PREP,
    RESP
  } state_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for the data memory: store byte-enables and lane
// replication, load lane selection with sign/zero extension, and detection
// of misaligned accesses and illegal size codes.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic        i_we,
  input  logic [1:0]  i_off,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rword,
  output logic [3:0]  o_be,
  output logic [31:0] o_wword,
  output logic [31:0] o_rdata,
  output logic        o_fault
);

  logic [31:0] w_rshift;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_rshift = i_rword >> {i_off, 3'b000};
  assign w_byte   = w_rshift[7:0];
  assign w_half   = i_off[1] ? i_rword[31:16] : i_rword[15:0];

  // Decode the size code into lane enables, aligned data and a fault flag.
  always_comb begin
    o_be    = '0;
    o_wword = '0;
    o_rdata = '0;
    o_fault = 1'b0;
    case (i_funct3)
      F3_B, F3_BU: begin
        o_be    = 4'b0001 << i_off;
        o_wword = {4{i_wdata[7:0]}};
        o_rdata = (i_funct3 == F3_B) ? {{24{w_byte[7]}}, w_byte} : {24'b0, w_byte};
        o_fault = i_we && (i_funct3 == F3_BU);
      end
      F3_H, F3_HU: begin
        o_be    = i_off[1] ? 4'b1100 : 4'b0011;
        o_wword = {2{i_wdata[15:0]}};
        o_rdata = (i_funct3 == F3_H) ? {{16{w_half[15]}}, w_half} : {16'b0, w_half};
        o_fault = i_off[0] || (i_we && (i_funct3 == F3_HU));
      end
      F3_W: begin
        o_be    = '1;
        o_wword = i_wdata;
        o_rdata = i_rword;
        o_fault = |i_off;
      end
      default: o_fault = 1'b1;
    endcase
    // A faulting access must neither write nor return data.
    if (o_fault) begin
      o_be    = '0;
      o_rdata = '0;
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store per transaction, waits a
// fixed number of cycles, performs the access and holds the response until
// the requester takes it.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH_WORDS) * 33'd4;
  localparam logic [3:0]  CNT_INIT   = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_cnt;
  logic        r_we;
  logic [31:0] r_addr;
  logic [2:0]  r_funct3;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic        r_err;
  logic [31:0] r_mem [DEPTH_WORDS];

  logic [AW-1:0] w_idx;
  logic          w_oob;
  logic [31:0]   w_rword;
  logic [3:0]    w_be;
  logic [31:0]   w_wword;
  logic [31:0]   w_ld;
  logic          w_align_fault;
  logic          w_fault;
  logic          w_commit;
  logic          w_accept;

  assign w_accept = (r_state == IDLE) && req_valid;
  assign w_idx    = r_addr[AW+1:2];
  assign w_oob    = ({1'b0, r_addr} >= ADDR_LIMIT);
  assign w_rword  = w_oob ? '0 : r_mem[w_idx];
  assign w_fault  = w_align_fault || w_oob;
  assign w_commit = (r_state == RESP_PREP) && r_we && !w_fault;

  dmem_lane_align u_align (
    .i_we     (r_we),
    .i_off    (r_addr[1:0]),
    .i_funct3 (r_funct3),
    .i_wdata  (r_wdata),
    .i_rword  (w_rword),
    .o_be     (w_be),
    .o_wword  (w_wword),
    .o_rdata  (w_ld),
    .o_fault  (w_align_fault)
  );

  // State register and wait-state counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept)
        r_cnt <= CNT_INIT;
      else if ((r_state == WAIT) && (r_cnt != '0))
        r_cnt <= r_cnt - 4'd1;
    end
  end

  // Request latch and registered response.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_funct3 <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_we     <= req_we;
        r_addr   <= req_addr;
        r_funct3 <= req_funct3;
        r_wdata  <= req_wdata;
      end
      if (r_state == RESP_PREP) begin
        r_rdata <= (r_we || w_fault) ? '0 : w_ld;
        r_err   <= w_fault;
      end
    end
  end

  // Memory array: byte-masked store commit, never cleared by reset.
  always_ff @(posedge clk) begin
    if (rst && w_commit) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (w_be[b])
          r_mem[w_idx][8*b +: 8] <= w_wword[8*b +: 8];
      end
    end
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:      if (req_valid) w_next = (WAIT_CYCLES == 0) ? RESP_PREP : WAIT;
      WAIT:      if (r_cnt == '0) w_next = RESP_PREP;
      RESP_PREP: w_next = RESP;
      RESP:      if (rsp_ready) w_next = IDLE;
      default:   w_next = IDLE;
    endcase
  end

  // Handshake outputs decoded from state; data from the response registers.
  always_comb begin
    req_ready = (r_state == IDLE);
    rsp_valid = (r_state == RESP);
    rsp_rdata = r_rdata;
    rsp_err   = r_err;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder with a byte-addressed reference memory.
module tb_dmem_responder;

  localparam int unsigned DW = 256;
  localparam int unsigned WC = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(DW), .WAIT_CYCLES(WC)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_funct3 (req_funct3),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  rsp_t       exp_q[$];
  logic [7:0] mdl [DW*4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  // Reference behaviour: size/alignment/range rules on a flat byte memory.
  function automatic rsp_t model_xact(input bit we, input logic [31:0] a,
                                      input logic [2:0] f3, input logic [31:0] wd);
    rsp_t        r;
    int unsigned size;
    bit          sgn;
    logic [31:0] v;
    logic [31:0] t;
    r.rdata = '0;
    r.err   = 1'b0;
    sgn     = 1'b0;
    case (f3)
      3'b000:  begin size = 1; sgn = 1'b1; end
      3'b001:  begin size = 2; sgn = 1'b1; end
      3'b010:  size = 4;
      3'b100:  size = 1;
      3'b101:  size = 2;
      default: size = 0;
    endcase
    if (size == 0) r.err = 1'b1;
    else if (a >= DW*4) r.err = 1'b1;
    else if ((a % size) != 0) r.err = 1'b1;
    else if (we && (f3 == 3'b100 || f3 == 3'b101)) r.err = 1'b1;
    if (!r.err) begin
      if (we) begin
        for (int unsigned k = 0; k < size; k++) begin
          t = wd >> (8*k);
          mdl[a+k] = t[7:0];
        end
      end else begin
        v = '0;
        for (int unsigned k = 0; k < size; k++)
          v = v | (32'(mdl[a+k]) << (8*k));
        if (sgn && v[8*size-1])
          v = v | ~((32'h1 << (8*size)) - 32'h1);
        r.rdata = v;
      end
    end
    return r;
  endfunction

  // Compare every cycle a response is presented against the oldest expectation.
  always @(negedge clk) begin
    if (rst && rsp_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_rsp: got rsp_valid=1 rdata=0x%08h, want no response pending", rsp_rdata);
      end else begin
        check("rsp_rdata", rsp_rdata, exp_q[0].rdata);
        check("rsp_err", 32'(rsp_err), 32'(exp_q[0].err));
        check("req_ready_in_resp", 32'(req_ready), 32'd0);
        if (rsp_ready) void'(exp_q.pop_front());
      end
    end
  end

  // One transaction; bp = cycles rsp_ready is held low once the response is up.
  task automatic txn(input string nm, input bit we, input logic [31:0] a, input logic [2:0] f3,
                     input logic [31:0] wd, input int bp,
                     input bit lit_en, input logic [31:0] lit_d, input bit lit_e);
    rsp_t e;
    int   n;
    e = model_xact(we, a, f3, wd);
    if (lit_en) begin
      check({nm, "_model_rdata"}, e.rdata, lit_d);
      check({nm, "_model_err"}, 32'(e.err), 32'(lit_e));
    end
    exp_q.push_back(e);
    check({nm, "_req_ready_idle"}, 32'(req_ready), 32'd1);
    req_valid  = 1'b1;
    req_we     = we;
    req_addr   = a;
    req_funct3 = f3;
    req_wdata  = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    // The accept edge counts as the first edge.
    n = 1;
    while (!rsp_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check({nm, "_latency_edges"}, 32'(n), 32'(WC + 2));
    for (int i = 0; i < bp; i++) begin
      @(posedge clk); #1;
      req_valid = (i == 1);
      if (i == 1) begin
        req_we     = 1'b1;
        req_addr   = 32'h10;
        req_funct3 = 3'b010;
        req_wdata  = 32'h0;
      end
      check({nm, "_bp_rsp_valid"}, 32'(rsp_valid), 32'd1);
      check({nm, "_bp_req_ready"}, 32'(req_ready), 32'd0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check({nm, "_done_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({nm, "_done_req_ready"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion, want $finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    check("reset_req_ready", 32'(req_ready), 32'd1);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_rsp_rdata", rsp_rdata, 32'h0);
    check("reset_rsp_err", 32'(rsp_err), 32'd0);

    //   name           we    addr     f3      wdata          bp lit data          err
    txn("sw_10",     1'b1, 32'h10,  3'b010, 32'hDEADBEEF, 0, 1'b1, 32'h00000000, 1'b0);
    txn("lw_10",     1'b0, 32'h10,  3'b010, 32'h0,        0, 1'b1, 32'hDEADBEEF, 1'b0);
    txn("sb_13",     1'b1, 32'h13,  3'b000, 32'h00000080, 0, 1'b1, 32'h00000000, 1'b0);
    txn("lb_13",     1'b0, 32'h13,  3'b000, 32'h0,        0, 1'b1, 32'hFFFFFF80, 1'b0);
    txn("lbu_13",    1'b0, 32'h13,  3'b100, 32'h0,        0, 1'b1, 32'h00000080, 1'b0);
    txn("lw_10_bp",  1'b0, 32'h10,  3'b010, 32'h0,        5, 1'b1, 32'h80ADBEEF, 1'b0);
    txn("lh_12",     1'b0, 32'h12,  3'b001, 32'h0,        0, 1'b1, 32'hFFFF80AD, 1'b0);
    txn("sh_11_mis", 1'b1, 32'h11,  3'b001, 32'h0000CAFE, 0, 1'b1, 32'h00000000, 1'b1);
    txn("lw_10_again",1'b0, 32'h10, 3'b010, 32'h0,        0, 1'b1, 32'h80ADBEEF, 1'b0);
    txn("lw_400_oob",1'b0, 32'h400, 3'b010, 32'h0,        0, 1'b1, 32'h00000000, 1'b1);
    txn("f3_011",    1'b0, 32'h10,  3'b011, 32'h0,        0, 1'b1, 32'h00000000, 1'b1);
    txn("lhu_10",    1'b0, 32'h10,  3'b101, 32'h0,        0, 1'b1, 32'h0000BEEF, 1'b0);
    txn("lb_11",     1'b0, 32'h11,  3'b000, 32'h0,        0, 1'b1, 32'hFFFFFFBE, 1'b0);
    txn("sbu_store", 1'b1, 32'h10,  3'b100, 32'h000000FF, 0, 1'b1, 32'h00000000, 1'b1);
    txn("lw_12_mis", 1'b0, 32'h12,  3'b010, 32'h0,        0, 1'b1, 32'h00000000, 1'b1);
    txn("sh_16",     1'b1, 32'h16,  3'b001, 32'h1234A5A5, 0, 1'b1, 32'h00000000, 1'b0);
    txn("lh_16",     1'b0, 32'h16,  3'b001, 32'h0,        0, 1'b1, 32'hFFFFA5A5, 1'b0);
    txn("lw_3fc",    1'b0, 32'h3FC, 3'b010, 32'h0,        0, 1'b0, 32'h0,         1'b0);
    txn("sw_20",     1'b1, 32'h20,  3'b010, 32'h0BADF00D, 0, 1'b1, 32'h00000000, 1'b0);

    // Store aborted by reset while waiting; the model is deliberately not updated.
    check("abort_req_ready", 32'(req_ready), 32'd1);
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_addr   = 32'h20;
    req_funct3 = 3'b010;
    req_wdata  = 32'h12345678;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    check("abort_req_ready_after", 32'(req_ready), 32'd1);
    check("abort_rsp_valid_after", 32'(rsp_valid), 32'd0);
    check("abort_rsp_rdata_after", rsp_rdata, 32'h0);
    check("abort_rsp_err_after", 32'(rsp_err), 32'd0);
    repeat (6) @(posedge clk);
    #1;
    check("abort_no_rsp", 32'(rsp_valid), 32'd0);
    txn("lw_20_pre", 1'b0, 32'h20, 3'b010, 32'h0, 0, 1'b1, 32'h0BADF00D, 1'b0);

    repeat (5) @(posedge clk);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
